// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch sequencer. Issues one instruction-memory
//               request per instruction from the current PC, buffers the
//               returned word for decode, and drives the next PC (+4 or a
//               redirect target) back into the PC register. Only one
//               request is outstanding at a time. Handles redirect flush,
//               access faults and misaligned PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int XLEN       = 64,
    parameter int ILEN       = 32,
    parameter int INST_BYTES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] npc_o,
    output logic            npc_we_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_fault_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [ILEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_fault;

    logic            w_misaligned;
    logic            w_redirect;
    logic            w_seq_write;
    logic            w_cap_misaligned;
    logic            w_cap_rsp;

    assign w_misaligned = |pc_i[1:0];
    // IDLE is the post-reset bubble; a redirect there has no effect.
    assign w_redirect   = redirect_i && (r_state != ST_IDLE);
    // Decode accepted a good instruction: advance sequentially.
    assign w_seq_write  = (r_state == ST_HOLD) && inst_ready_i && !r_fault;

    // Buffer load sources; a same-cycle redirect wins and nothing is loaded.
    assign w_cap_misaligned = (r_state == ST_REQ)  && !redirect_i && w_misaligned;
    assign w_cap_rsp        = (r_state == ST_WAIT) && !redirect_i && imem_rsp_valid_i;

    // Next-state selection for the fetch sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (!redirect_i) begin
                    if (w_misaligned) begin
                        w_state_nxt = ST_HOLD;
                    end else if (imem_req_ready_i) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    // A response in the same cycle is the stale one: drop it now.
                    w_state_nxt = imem_rsp_valid_i ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid_i) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                // The outstanding response is discarded whenever it arrives.
                if (imem_rsp_valid_i) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    w_state_nxt = ST_REQ;
                end else if (inst_ready_i) begin
                    w_state_nxt = r_fault ? ST_FAULT : ST_REQ;
                end
            end
            ST_FAULT: begin
                if (redirect_i) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction buffer: loaded from a response or a misaligned-PC fault entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_fault   <= 1'b0;
        end else if (w_cap_misaligned) begin
            r_inst    <= '0;
            r_inst_pc <= pc_i;
            r_fault   <= 1'b1;
        end else if (w_cap_rsp) begin
            r_inst    <= imem_rsp_err_i ? '0 : imem_rsp_data_i;
            r_inst_pc <= pc_i;
            r_fault   <= imem_rsp_err_i;
        end
    end

    // Request is withdrawn only by a redirect; address follows the PC register.
    assign imem_req_valid_o = (r_state == ST_REQ) && !redirect_i && !w_misaligned;
    assign imem_req_addr_o  = pc_i;

    assign inst_valid_o = (r_state == ST_HOLD);
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_fault_o = r_fault;

    // Redirect overrides a sequential write in the same cycle.
    assign npc_we_o = w_redirect || w_seq_write;
    assign npc_o    = w_redirect ? redirect_pc_i : (r_inst_pc + XLEN'(INST_BYTES));

    // Responses are only legal while a request is outstanding.
    a_rsp_protocol: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rsp_valid_i |-> ((r_state == ST_WAIT) || (r_state == ST_DRAIN)));

endmodule
`default_nettype wire
